// File: rtl/if_id_fetch_queue_pkg.sv
// Shared constants and helpers for the IF->ID fetch queue.
// Holds the NOP encoding, the default word width, the default depth and a saturating adder.
package if_id_fetch_queue_pkg;

    localparam int unsigned    FQ_WORD_W   = 16;
    localparam int unsigned    FQ_DEPTH    = 4;
    localparam logic [15:0]    FQ_NOP_WORD = 16'h0000;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? '1 : sum[15:0];
    endfunction

endpackage

// File: rtl/if_id_fetch_queue_mem.sv
// Storage array for the fetch queue: one synchronous write port and one asynchronous read port.
// The storage itself is not reset; validity is tracked by the pointers and count in the top level.
module if_id_queue_mem
    import if_id_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = FQ_DEPTH,
    parameter int unsigned DATA_W = 2 * FQ_WORD_W,
    parameter int unsigned ADDR_W = $clog2(FQ_DEPTH)
)(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_id_fetch_queue.sv
// Fetch queue between IF and ID: buffers {pc, instr}, shows a NOP bubble when empty or flushing.
// Optional statistics counters are enabled by defining FETCH_QUEUE_STATS_EN.
module if_id_fetch_queue
    import if_id_fetch_queue_pkg::*;
#(
    parameter int unsigned       DEPTH    = FQ_DEPTH,
    parameter int unsigned       WORD_W   = FQ_WORD_W,
    parameter logic [WORD_W-1:0] NOP_WORD = WORD_W'(FQ_NOP_WORD)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [WORD_W-1:0] if_instr,
    input  logic [WORD_W-1:0] if_pc,
    output logic              if_ready,
    input  logic              IF_ID_sync_nop,
    input  logic              id_stall,
    output logic [WORD_W-1:0] id_instr,
    output logic [WORD_W-1:0] id_pc,
    output logic              id_is_nop
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [15:0]       flush_cnt,
    output logic [15:0]       discard_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                full;
    logic                bubble;
    logic                enq;
    logic                deq;
    logic [2*WORD_W-1:0] head_data;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign if_ready = ~full & ~IF_ID_sync_nop;
    assign enq      = if_valid & if_ready;
    assign bubble   = (count_q == '0) | IF_ID_sync_nop;
    assign deq      = ~bubble & ~id_stall;

    if_id_queue_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (2 * WORD_W),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (enq),
        .waddr (wr_ptr_q),
        .wdata ({if_pc, if_instr}),
        .raddr (rd_ptr_q),
        .rdata (head_data)
    );

    always_comb begin
        id_instr  = NOP_WORD;
        id_pc     = '0;
        id_is_nop = 1'b1;
        if (!bubble) begin
            id_pc     = head_data[2*WORD_W-1:WORD_W];
            id_instr  = head_data[WORD_W-1:0];
            id_is_nop = 1'b0;
        end
    end

    // Flush wins over enq/deq; otherwise enq and deq together leave count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (IF_ID_sync_nop) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [15:0] discard_cnt_q, discard_cnt_d;

    always_comb begin
        flush_cnt_d   = flush_cnt_q;
        discard_cnt_d = discard_cnt_q;
        if (IF_ID_sync_nop) begin
            flush_cnt_d   = sat_add16(flush_cnt_q, 16'd1);
            discard_cnt_d = sat_add16(discard_cnt_q, 16'(count_q));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_q   <= '0;
            discard_cnt_q <= '0;
        end else begin
            flush_cnt_q   <= flush_cnt_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    assign flush_cnt   = flush_cnt_q;
    assign discard_cnt = discard_cnt_q;
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(enq && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(deq && (count_q == '0)));

endmodule
